// File: rtl/ext_irq_if.sv
// Interrupt-controller bus: device lines, mask write port and core handshake.
interface ext_irq_if #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
);
  logic [N_SRC-1:0] irq_src;
  logic             irq_mask_we;
  logic [N_SRC-1:0] irq_mask_wdata;
  logic             ExtlAck;
  logic             ERet;
  logic             ExtIRQ;
  logic [ID_W-1:0]  irq_id;
  logic [N_SRC-1:0] irq_pending;
  logic [N_SRC-1:0] irq_mask;

  modport slave (
    input  irq_src, irq_mask_we, irq_mask_wdata, ExtlAck, ERet,
    output ExtIRQ, irq_id, irq_pending, irq_mask
  );

  modport master (
    output irq_src, irq_mask_we, irq_mask_wdata, ExtlAck, ERet,
    input  ExtIRQ, irq_id, irq_pending, irq_mask
  );
endinterface

// File: rtl/ext_irq_controller.sv
// External interrupt controller: edge-latched pending bits, fixed priority, one request at a time.
// EXT_IRQ_SYNC_EN adds a 2-flop input synchronizer ahead of edge detection.
module ext_irq_controller #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
) (
  input  logic     clk,
  input  logic     reset,
  ext_irq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

  state_e           state_q, state_d;
  logic [N_SRC-1:0] src_s, src_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] rise, eligible, clr;
  logic [ID_W-1:0]  id_q, id_d, sel_id;
  logic             ext_irq_q, ext_irq_d;

`ifdef EXT_IRQ_SYNC_EN
  logic [N_SRC-1:0] sync1_q, sync2_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.irq_src;
      sync2_q <= sync1_q;
    end
  end
  assign src_s = sync2_q;
`else
  assign src_s = bus.irq_src;
`endif

  assign rise     = src_s & ~src_q;
  assign eligible = pending_q & mask_q;

  // Lowest index wins: scan downward so the last hit is the smallest.
  always_comb begin
    sel_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (eligible[i]) sel_id = ID_W'(i);
  end

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    ext_irq_d = 1'b0;
    clr       = '0;
    case (state_q)
      IDLE: if (|eligible) begin
        id_d      = sel_id;
        state_d   = REQ;
        ext_irq_d = 1'b1;
      end
      REQ: begin
        ext_irq_d = 1'b1;
        if (bus.ExtlAck) begin
          clr[id_q] = 1'b1;
          state_d   = SERVICE;
          ext_irq_d = 1'b0;
        end
      end
      SERVICE: if (bus.ERet) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A rise in the same cycle as the ack clear keeps the bit pending.
  assign pending_d = (pending_q & ~clr) | rise;
  assign mask_d    = bus.irq_mask_we ? bus.irq_mask_wdata : mask_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      src_q     <= '0;
      pending_q <= '0;
      mask_q    <= '1;
      id_q      <= '0;
      ext_irq_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_s;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      id_q      <= id_d;
      ext_irq_q <= ext_irq_d;
    end
  end

  assign bus.ExtIRQ      = ext_irq_q;
  assign bus.irq_id      = id_q;
  assign bus.irq_pending = pending_q;
  assign bus.irq_mask    = mask_q;
endmodule

// File: tb/tb_ext_irq_controller.sv
// Directed bench for ext_irq_controller: latency, priority, masking, set-wins and async reset.
module tb_ext_irq_controller;
`ifdef EXT_IRQ_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  ext_irq_if #(.N_SRC(4), .ID_W(2)) bus ();

  ext_irq_controller #(.N_SRC(4), .ID_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    bus.ExtlAck = 1'b1;
    step(1);
    bus.ExtlAck = 1'b0;
  endtask

  task automatic pulse_eret();
    bus.ERet = 1'b1;
    step(1);
    bus.ERet = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(2);
    tests++; if (bus.ExtIRQ !== 1'b0) begin fails++; $display("FAIL reset_extirq got=%b exp=0", bus.ExtIRQ); end
    tests++; if (bus.irq_id !== 2'd0) begin fails++; $display("FAIL reset_id got=%0d exp=0", bus.irq_id); end
    tests++; if (bus.irq_pending !== 4'b0000) begin fails++; $display("FAIL reset_pending got=%b exp=0000", bus.irq_pending); end
    tests++; if (bus.irq_mask !== 4'b1111) begin fails++; $display("FAIL reset_mask got=%b exp=1111", bus.irq_mask); end
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_basic();
    bus.irq_src = 4'b0100;
    step(1 + SYNC);
    tests++; if (bus.irq_pending !== 4'b0100) begin fails++; $display("FAIL basic_pending got=%b exp=0100", bus.irq_pending); end
    tests++; if (bus.ExtIRQ !== 1'b0) begin fails++; $display("FAIL basic_not_early got=%b exp=0", bus.ExtIRQ); end
    step(1);
    tests++; if (bus.ExtIRQ !== 1'b1 || bus.irq_id !== 2'd2) begin fails++; $display("FAIL basic_req got=%b/%0d exp=1/2", bus.ExtIRQ, bus.irq_id); end
    step(3);
    pulse_eret();
    tests++; if (bus.ExtIRQ !== 1'b1 || bus.irq_id !== 2'd2) begin fails++; $display("FAIL basic_hold_eret got=%b/%0d exp=1/2", bus.ExtIRQ, bus.irq_id); end
    pulse_ack();
    tests++; if (bus.ExtIRQ !== 1'b0 || bus.irq_pending !== 4'b0000) begin fails++; $display("FAIL basic_ack got=%b/%b exp=0/0000", bus.ExtIRQ, bus.irq_pending); end
    bus.irq_src = 4'b0001;
    step(1 + SYNC);
    tests++; if (bus.irq_pending !== 4'b0001) begin fails++; $display("FAIL svc_pending got=%b exp=0001", bus.irq_pending); end
    step(2);
    tests++; if (bus.ExtIRQ !== 1'b0) begin fails++; $display("FAIL svc_blocked got=%b exp=0", bus.ExtIRQ); end
    pulse_ack();
    tests++; if (bus.irq_pending !== 4'b0001) begin fails++; $display("FAIL svc_ack_ignored got=%b exp=0001", bus.irq_pending); end
    pulse_eret();
    tests++; if (bus.ExtIRQ !== 1'b0) begin fails++; $display("FAIL eret_idle got=%b exp=0", bus.ExtIRQ); end
    step(1);
    tests++; if (bus.ExtIRQ !== 1'b1 || bus.irq_id !== 2'd0) begin fails++; $display("FAIL eret_next_req got=%b/%0d exp=1/0", bus.ExtIRQ, bus.irq_id); end
    pulse_ack();
    pulse_eret();
    bus.irq_src = 4'b0000;
    step(3);
  endtask

  task automatic test_priority();
    bus.irq_src = 4'b1010;
    step(2 + SYNC);
    tests++; if (bus.ExtIRQ !== 1'b1 || bus.irq_id !== 2'd1) begin fails++; $display("FAIL prio_first got=%b/%0d exp=1/1", bus.ExtIRQ, bus.irq_id); end
    tests++; if (bus.irq_pending !== 4'b1010) begin fails++; $display("FAIL prio_pending got=%b exp=1010", bus.irq_pending); end
    pulse_ack();
    tests++; if (bus.irq_pending !== 4'b1000) begin fails++; $display("FAIL prio_clear got=%b exp=1000", bus.irq_pending); end
    pulse_eret();
    step(1);
    tests++; if (bus.ExtIRQ !== 1'b1 || bus.irq_id !== 2'd3) begin fails++; $display("FAIL prio_second got=%b/%0d exp=1/3", bus.ExtIRQ, bus.irq_id); end
    pulse_ack();
    pulse_eret();
    bus.irq_src = 4'b0000;
    step(3);
  endtask

  task automatic test_mask();
    bus.irq_mask_we = 1'b1; bus.irq_mask_wdata = 4'b1110;
    step(1);
    bus.irq_mask_we = 1'b0;
    tests++; if (bus.irq_mask !== 4'b1110) begin fails++; $display("FAIL mask_write got=%b exp=1110", bus.irq_mask); end
    bus.irq_src = 4'b0001;
    step(1 + SYNC);
    tests++; if (bus.irq_pending !== 4'b0001) begin fails++; $display("FAIL mask_pending got=%b exp=0001", bus.irq_pending); end
    step(2);
    tests++; if (bus.ExtIRQ !== 1'b0) begin fails++; $display("FAIL mask_blocked got=%b exp=0", bus.ExtIRQ); end
    bus.irq_mask_we = 1'b1; bus.irq_mask_wdata = 4'b1111;
    step(1);
    bus.irq_mask_we = 1'b0;
    tests++; if (bus.ExtIRQ !== 1'b0) begin fails++; $display("FAIL unmask_edge got=%b exp=0", bus.ExtIRQ); end
    step(1);
    tests++; if (bus.ExtIRQ !== 1'b1 || bus.irq_id !== 2'd0) begin fails++; $display("FAIL unmask_req got=%b/%0d exp=1/0", bus.ExtIRQ, bus.irq_id); end
    bus.irq_mask_we = 1'b1; bus.irq_mask_wdata = 4'b0000;
    step(1);
    bus.irq_mask_we = 1'b0;
    step(1);
    tests++; if (bus.ExtIRQ !== 1'b1 || bus.irq_id !== 2'd0) begin fails++; $display("FAIL mask_in_req got=%b/%0d exp=1/0", bus.ExtIRQ, bus.irq_id); end
    pulse_ack();
    tests++; if (bus.ExtIRQ !== 1'b0 || bus.irq_pending !== 4'b0000) begin fails++; $display("FAIL mask_ack got=%b/%b exp=0/0000", bus.ExtIRQ, bus.irq_pending); end
    pulse_eret();
    bus.irq_mask_we = 1'b1; bus.irq_mask_wdata = 4'b1111;
    step(1);
    bus.irq_mask_we = 1'b0;
    bus.irq_src = 4'b0000;
    step(3);
  endtask

  task automatic test_set_wins();
    bus.irq_src = 4'b0100;
    step(2 + SYNC);
    tests++; if (bus.ExtIRQ !== 1'b1 || bus.irq_id !== 2'd2) begin fails++; $display("FAIL setwin_req got=%b/%0d exp=1/2", bus.ExtIRQ, bus.irq_id); end
    bus.irq_src = 4'b0000;
    step(1);
    bus.irq_src = 4'b0100;
    if (SYNC > 0) step(SYNC);
    // ack and ERet together in REQ: only the ack counts
    bus.ExtlAck = 1'b1; bus.ERet = 1'b1;
    step(1);
    bus.ExtlAck = 1'b0; bus.ERet = 1'b0;
    tests++; if (bus.irq_pending !== 4'b0100 || bus.ExtIRQ !== 1'b0) begin fails++; $display("FAIL setwin_pending got=%b/%b exp=0100/0", bus.irq_pending, bus.ExtIRQ); end
    step(2);
    tests++; if (bus.ExtIRQ !== 1'b0) begin fails++; $display("FAIL ack_eret_same got=%b exp=0", bus.ExtIRQ); end
    pulse_eret();
    step(1);
    tests++; if (bus.ExtIRQ !== 1'b1 || bus.irq_id !== 2'd2) begin fails++; $display("FAIL setwin_rereq got=%b/%0d exp=1/2", bus.ExtIRQ, bus.irq_id); end
  endtask

  task automatic test_reset_mid();
    bus.irq_mask_we = 1'b1; bus.irq_mask_wdata = 4'b0101;
    step(1);
    bus.irq_mask_we = 1'b0;
    tests++; if (bus.ExtIRQ !== 1'b1 || bus.irq_mask !== 4'b0101) begin fails++; $display("FAIL pre_reset got=%b/%b exp=1/0101", bus.ExtIRQ, bus.irq_mask); end
    #2 reset = 1'b1;
    #1;
    tests++; if (bus.ExtIRQ !== 1'b0) begin fails++; $display("FAIL async_extirq got=%b exp=0", bus.ExtIRQ); end
    tests++; if (bus.irq_pending !== 4'b0000) begin fails++; $display("FAIL async_pending got=%b exp=0000", bus.irq_pending); end
    tests++; if (bus.irq_mask !== 4'b1111) begin fails++; $display("FAIL async_mask got=%b exp=1111", bus.irq_mask); end
    tests++; if (bus.irq_id !== 2'd0) begin fails++; $display("FAIL async_id got=%0d exp=0", bus.irq_id); end
    bus.irq_src = 4'b0000;
    step(2);
    reset = 1'b0;
    step(3);
    tests++; if (bus.ExtIRQ !== 1'b0 || bus.irq_pending !== 4'b0000) begin fails++; $display("FAIL post_reset got=%b/%b exp=0/0000", bus.ExtIRQ, bus.irq_pending); end
  endtask

  initial begin
    reset              = 1'b1;
    bus.irq_src        = '0;
    bus.irq_mask_we    = 1'b0;
    bus.irq_mask_wdata = '0;
    bus.ExtlAck        = 1'b0;
    bus.ERet           = 1'b0;
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_set_wins();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ext_irq_controller.md
Name: ext_irq_controller

Overview:
- External interrupt source for the exception-capable LEGv8 core.
- Collects device interrupt lines, latches rising edges as pending, and selects the highest-priority enabled one.
- Drives the core's ExtIRQ with a registered request, holds it until the core returns ExtlAck, then waits for ERet before issuing the next request.
- Sits between peripherals and the processor; one outstanding interrupt at a time, no nesting.

Parameters:
- N_SRC, 4, number of interrupt source lines.
- ID_W, 2, width of irq_id; must satisfy 2**ID_W >= N_SRC.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- irq_src  in  N_SRC  device interrupt lines, level-held by devices; only rising edges matter.
- irq_mask_we  in  1  write strobe for the enable mask.
- irq_mask_wdata  in  N_SRC  new mask value; bit = 1 enables that source.
- ExtlAck  in  1  acknowledge from the core controller.
- ERet  in  1  exception-return pulse from the core.
- ExtIRQ  out  1  registered interrupt request to the core.
- irq_id  out  ID_W  index of the source being requested/serviced.
- irq_pending  out  N_SRC  current pending register.
- irq_mask  out  N_SRC  current enable mask.

Behaviour:
- Reset values: ExtIRQ=0, irq_id=0, irq_pending=0, irq_mask=all 1s, edge-history register=0, FSM=IDLE. All are asynchronous and take effect mid-operation from any state.
- Edge detect:
  - rise = irq_src & ~src_q, where src_q is irq_src delayed one cycle.
  - pending |= rise every cycle.
  - Latching ignores the mask; a masked edge stays pending.
- Mask: on irq_mask_we, irq_mask <= irq_mask_wdata on the next edge. It affects selection only.
- Eligible set = pending & irq_mask. Priority is fixed: lowest index wins (bit 0 is highest).
- FSM, three states:
  - IDLE: ExtIRQ=0. If eligible != 0, latch irq_id = lowest set index and move to REQ.
  - REQ: ExtIRQ=1 (registered output, high for the whole state). irq_id is held stable. The mask is still writable, but a mask write does not withdraw the request. On ExtlAck=1: clear pending[irq_id] and move to SERVICE, so ExtIRQ falls the following cycle.
  - SERVICE: ExtIRQ=0 and irq_id is held. On ERet=1, move to IDLE. A new request can assert at the earliest 1 cycle after returning to IDLE.
- Latency: a rising edge sampled at cycle t sets pending at t+1; FSM enters REQ with ExtIRQ=1 at t+2, starting from IDLE.
- Boundary conditions:
  - ExtlAck in IDLE or SERVICE: ignored.
  - ERet in IDLE or REQ: ignored.
  - New rise on bit k in the same cycle as the ack clears pending[k]: set wins, and bit k stays pending.
  - Repeated edges on an already-pending bit are not counted.
  - Eligible becoming 0 during REQ (mask write): request still completes.
  - ExtlAck and ERet both high in REQ: only the ack is taken; ERet is ignored in that cycle.

Optional Feature:
- Macro: EXT_IRQ_SYNC_EN.
- When defined: irq_src passes through a 2-flop synchronizer (reset to 0) before edge detection. Edge-to-ExtIRQ latency becomes 4 cycles.
- When undefined: irq_src feeds edge detection directly. Latency is 2 cycles, and sources must be synchronous to clk.

Test Plan:
- Reset, then irq_src=4'b0100 rising at cycle 5 -> irq_pending=4'b0100 at cycle 6; ExtIRQ=1 and irq_id=2 at cycle 7; ExtIRQ stays 1 until ExtlAck.
- In REQ with irq_id=2, pulse ExtlAck -> next cycle ExtIRQ=0 and pending=0. A second request is blocked until ERet is pulsed; ERet in REQ is ignored.
- Rising edges on bits 3 and 1 in the same cycle -> irq_id=1 first. After ExtlAck+ERet, ExtIRQ reasserts with irq_id=3.
- Mask=4'b1110, edge on bit 0 -> pending=4'b0001, ExtIRQ stays 0. Write mask=4'b1111 -> ExtIRQ=1 with irq_id=0 two cycles after the write edge.
- Same-cycle rise on bit 2 while ExtlAck clears bit 2 -> pending[2] remains 1, and a new request for id 2 follows ERet.
- Assert reset during REQ -> ExtIRQ=0, pending=0, mask=4'b1111 immediately. With EXT_IRQ_SYNC_EN, the first test's ExtIRQ moves to cycle 9.
